// File: rtl/alu_mdu_if.sv
// Command/result bundle for the execute-stage arithmetic unit.
// The master drives commands and flush; the slave returns handshake, results and busy.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;
    logic             busy;

    modport master (
        output flush, in_valid, exe_cmd, val1, val2,
        input  in_ready, out_valid, alu_res, busy
    );

    modport slave (
        input  flush, in_valid, exe_cmd, val1, val2,
        output in_ready, out_valid, alu_res, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with single-cycle ops and iterative shift-add multiply /
// restoring divide; results are registered and pulse out_valid once.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             sel_hi;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;

    logic             accept;
    logic             last;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   dtrial;
    logic             dok;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign bus.in_ready  = (state == IDLE) & rst_n;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.alu_res   = alu_res;

    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign last   = (cnt == SHW'(WIDTH - 1));
    assign shamt  = bus.val2[SHW-1:0];

    always_comb begin
        sc_res = '0;
        case (bus.exe_cmd)
            4'd0:  sc_res = bus.val1 + bus.val2;
            4'd2:  sc_res = bus.val1 - bus.val2;
            4'd4:  sc_res = bus.val1 & bus.val2;
            4'd5:  sc_res = bus.val1 | bus.val2;
            4'd6:  sc_res = ~(bus.val1 | bus.val2);
            4'd7:  sc_res = bus.val1 ^ bus.val2;
            4'd8:  sc_res = bus.val1 << shamt;
            4'd9:  sc_res = $unsigned($signed(bus.val1) >>> shamt);
            4'd10: sc_res = bus.val1 >> shamt;
            4'd11: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.val1) < $signed(bus.val2)};
            default: sc_res = '0;
        endcase
    end

    // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
    always_comb begin
        msum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
        mul_hi_n = msum[WIDTH:1];
        mul_lo_n = {msum[0], lo[WIDTH-1:1]};
    end

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    // A zero divisor always succeeds, yielding all-ones quotient and remainder = dividend.
    always_comb begin
        dtrial   = {hi, lo[WIDTH-1]} - {1'b0, opnd};
        dok      = ~dtrial[WIDTH];
        div_hi_n = dok ? dtrial[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
        div_lo_n = {lo[WIDTH-2:0], dok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_hi    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            out_valid <= 1'b0;
            alu_res   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    if (bus.exe_cmd[3:2] == 2'b11) begin
                        sel_hi <= bus.exe_cmd[0];
                        hi     <= '0;
                        if (bus.exe_cmd[1]) begin
                            lo    <= bus.val1;
                            opnd  <= bus.val2;
                            state <= DIV;
                        end else begin
                            lo    <= bus.val2;
                            opnd  <= bus.val1;
                            state <= MUL;
                        end
                    end else begin
                        alu_res   <= sc_res;
                        out_valid <= 1'b1;
                    end
                end
                MUL: if (bus.flush) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    hi  <= mul_hi_n;
                    lo  <= mul_lo_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        alu_res   <= sel_hi ? mul_hi_n : mul_lo_n;
                        out_valid <= 1'b1;
                    end
                end
                DIV: if (bus.flush) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    hi  <= div_hi_n;
                    lo  <= div_lo_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        alu_res   <= sel_hi ? div_hi_n : div_lo_n;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the MIPS pipeline. It keeps the existing 4-bit `exe_cmd` encoding for single-cycle ALU operations at any `WIDTH`, and adds iterative multiply and divide. Results are registered. Operands enter through a valid/ready handshake, and `busy` tells the hazard unit to stall the pipeline while a multi-cycle operation runs.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk`  in  1: clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: abort any in-flight operation (branch or exception squash).
- `in_valid`  in  1: command present on `exe_cmd`/`val1`/`val2`.
- `in_ready`  out  1: unit can accept a command this cycle.
- `exe_cmd`  in  4: operation code.
- `val1`, `val2`  in  WIDTH: operands.
- `out_valid`  out  1: one-cycle pulse; `alu_res` holds a new result.
- `alu_res`  out  WIDTH: registered result; holds its value between pulses.
- `busy`  out  1: multi-cycle operation in progress.

## Operation
- Acceptance: on a rising edge with `in_valid & in_ready & !flush`.
- Single-cycle commands (result = f(`val1`, `val2`)):
  - 0 add, 2 sub, 4 and, 5 or, 6 nor, 7 xor: modulo 2^WIDTH.
  - 8 sll, 10 srl, 9 sra: shift amount is `val2[SHW-1:0]`, upper bits ignored. Sra treats `val1` as signed and replicates `val1[WIDTH-1]`.
  - 11 slt: signed compare; result 1 if `val1` < `val2`, else 0.
  - 1, 3: reserved; result 0 and `out_valid` still pulses.
- Multi-cycle commands (unsigned operands):
  - 12 mul: low WIDTH bits of the product.
  - 13 mulhu: high WIDTH bits of the 2·WIDTH-bit product.
  - 14 divu: quotient.
  - 15 remu: remainder.
- Datapath:
  - Multiply: shift-add, one bit per cycle, 2·WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- Divide by zero: quotient is all ones; remainder is `val1`. The operation runs the full iteration count (no early exit).
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on acceptance of cmd 12/13; IDLE → DIV on acceptance of cmd 14/15.
  - MUL/DIV → IDLE after iteration counter reaches WIDTH−1, or on `flush`.
  - Single-cycle commands never leave IDLE.
- `in_ready` = (state == IDLE) & `rst_n`.
- `busy` = (state != IDLE).
- Operands and command are latched at acceptance. Input changes during MUL/DIV are ignored.
- `flush`:
  - In MUL/DIV: state goes to IDLE at the next edge, no `out_valid` for the aborted op, `alu_res` unchanged.
  - In IDLE: same-edge acceptance is suppressed.
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE, counter = 0, `out_valid` = 0, `alu_res` = 0, accumulators = 0.
  - Outputs during reset: `busy` = 0, `in_ready` = 0.

## Timing
- Single-cycle op accepted at edge E0: `alu_res` and `out_valid` = 1 are visible after E0 and low again after E0+1, unless another op is accepted at E0+1. Back-to-back single-cycle ops give one result per cycle.
- Multi-cycle op accepted at E0:
  - Iterations happen at edges E1…E_WIDTH.
  - At E_WIDTH: state ← IDLE, `alu_res` ← result, `out_valid` ← 1.
  - Latency is WIDTH cycles (32 for the default).
  - `in_ready` is 0 and `busy` is 1 from after E0 to after E_WIDTH.
  - A new command can be accepted at E_WIDTH+1, the same cycle `out_valid` is high.
- `flush` asserted in the cycle ending at E_WIDTH wins: no result, state IDLE.
- No output backpressure. The consumer must take `alu_res` in the `out_valid` cycle.

## Test plan
- Reset: `rst_n` low mid-divide (cycle 10) → immediately `busy` = 0, `in_ready` = 0, `alu_res` = 0, `out_valid` = 0. After release, `in_ready` = 1 and add 2+3 returns 5 one cycle later.
- Single-cycle sweep (WIDTH = 32), one op per cycle, each result one cycle after its command:
  - sub 5−7 → 0xFFFFFFFE.
  - sra 0x80000000 by `val2` = 0x24 (shamt 4) → 0xF8000000.
  - srl same operands → 0x08000000.
  - slt −1 < 1 → 1.
  - nor 0,0 → 0xFFFFFFFF.
  - cmd 3 → 0.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF:
  - mul → 0x00000001 after exactly 32 cycles.
  - mulhu → 0xFFFFFFFE.
  - `in_ready` low for those 32 cycles and `in_valid` ignored.
- Divide:
  - divu 100/7 → 14; remu → 2.
  - divu 9/0 → 0xFFFFFFFF; remu 9/0 → 9.
  - A divu issued in the `out_valid` cycle is accepted back-to-back.
- Flush:
  - Flush at cycle 5 of a mul → no `out_valid`, `alu_res` keeps its previous value, `in_ready` = 1 the next cycle.
  - Flush coincident with `in_valid` in IDLE → no acceptance.
- Parametrisation: WIDTH = 8 gives 0xFF × 0x02 mulhu → 0x01 in 8 cycles, and sll by `val2` = 0x0B shifts by 3.
